// File: rtl/can_rx_frame_if.sv
// rtl/can_rx_frame_if.sv - Destuffed bit-stream input and decoded frame result bundle for can_rx_frame.
interface can_rx_frame_if;
  logic        i_Bit_Valid;
  logic        i_Rx_Bit;
  logic        i_Ignora_Bit;
  logic        i_Eror_Stuffing;
  logic        o_Frame_Valid;
  logic [10:0] o_Id;
  logic        o_Rtr;
  logic [3:0]  o_Dlc;
  logic [63:0] o_Data;
  logic        o_Error;
  logic [2:0]  o_Error_Code;
  logic        o_Busy;

  modport master (
    output i_Bit_Valid, i_Rx_Bit, i_Ignora_Bit, i_Eror_Stuffing,
    input  o_Frame_Valid, o_Id, o_Rtr, o_Dlc, o_Data, o_Error, o_Error_Code, o_Busy
  );

  modport slave (
    input  i_Bit_Valid, i_Rx_Bit, i_Ignora_Bit, i_Eror_Stuffing,
    output o_Frame_Valid, o_Id, o_Rtr, o_Dlc, o_Data, o_Error, o_Error_Code, o_Busy
  );
endinterface

// File: rtl/can_rx_frame.sv
// rtl/can_rx_frame.sv - CAN 2.0A standard-frame receive parser placed behind the bit destuffer.
// Define CAN_RX_CRC_CHECK_EN to compute and verify CRC-15; otherwise the CRC field is discarded.
module can_rx_frame #(
  parameter int MAX_BYTES = 8
) (
  input logic           i_Clock,
  input logic           i_Reset,
  can_rx_frame_if.slave bus
);

  localparam logic [3:0] MAX_B     = 4'(MAX_BYTES);
  localparam logic [2:0] ERR_STUFF = 3'd1;
  localparam logic [2:0] ERR_FORM  = 3'd2;
  localparam logic [2:0] ERR_CRC   = 3'd3;
  localparam logic [2:0] ERR_IDE   = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA, S_CRC,
    S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF, S_INTERM, S_WAIT_IDLE
  } state_t;

  state_t      state, state_next;
  logic [5:0]  bit_cnt, cnt_next;
  logic [10:0] id_sr;
  logic        rtr_sr;
  logic [3:0]  dlc_sr;
  logic [63:0] data_sr;
  logic [5:0]  data_last;

  logic        frame_valid_r, error_r, rtr_r;
  logic [2:0]  error_code_r;
  logic [10:0] id_r;
  logic [3:0]  dlc_r;
  logic [63:0] data_r;

  logic        rx, stuff_zone, bit_ok;
  logic        err_hit, frame_done, crc_field_bad;
  logic [2:0]  err_cause;
  logic [3:0]  dlc_full, byte_cnt;
  logic [5:0]  data_last_nx;

  assign rx         = bus.i_Rx_Bit;
  assign stuff_zone = state inside {S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA, S_CRC};
  // A strobe carries a field bit unless the destuffer flagged it inside the stuffed region.
  assign bit_ok     = bus.i_Bit_Valid && !(stuff_zone && (bus.i_Ignora_Bit || bus.i_Eror_Stuffing));

  always_comb begin
    dlc_full = {dlc_sr[2:0], rx};
    if (rtr_sr)
      byte_cnt = 4'd0;
    else if (dlc_full > MAX_B)
      byte_cnt = MAX_B;
    else
      byte_cnt = dlc_full;
    data_last_nx = 6'({byte_cnt, 3'b000} - 7'd1);
  end

`ifdef CAN_RX_CRC_CHECK_EN
  logic [14:0] crc, rx_crc, crc_step;
  logic        crc_zone;

  assign crc_step      = {crc[13:0], 1'b0} ^ ((rx ^ crc[14]) ? 15'h4599 : 15'h0000);
  assign crc_zone      = state inside {S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA};
  assign crc_field_bad = ({rx_crc[13:0], rx} != crc);

  // SOF is dominant, so seeding the zeroed register with it leaves it at zero.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      crc    <= '0;
      rx_crc <= '0;
    end else if (bit_ok) begin
      if (state == S_IDLE)
        crc <= '0;
      else if (crc_zone)
        crc <= crc_step;
      else if (state == S_CRC)
        rx_crc <= {rx_crc[13:0], rx};
    end
  end
`else
  assign crc_field_bad = 1'b0;
`endif

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = bit_cnt;
    err_hit    = 1'b0;
    err_cause  = 3'd0;
    frame_done = 1'b0;
    if (bus.i_Bit_Valid) begin
      if (stuff_zone && bus.i_Eror_Stuffing) begin
        err_hit   = 1'b1;
        err_cause = ERR_STUFF;
      end else if (bit_ok) begin
        case (state)
          S_IDLE: if (!rx && !bus.i_Ignora_Bit) begin
            state_next = S_ID;
            cnt_next   = '0;
          end
          S_ID: if (bit_cnt == 6'd10) begin
            state_next = S_RTR;
            cnt_next   = '0;
          end else cnt_next = bit_cnt + 6'd1;
          S_RTR: state_next = S_IDE;
          S_IDE: if (rx) begin
            err_hit   = 1'b1;
            err_cause = ERR_IDE;
          end else state_next = S_R0;
          S_R0: state_next = S_DLC;
          S_DLC: if (bit_cnt == 6'd3) begin
            state_next = (byte_cnt == 4'd0) ? S_CRC : S_DATA;
            cnt_next   = '0;
          end else cnt_next = bit_cnt + 6'd1;
          S_DATA: if (bit_cnt == data_last) begin
            state_next = S_CRC;
            cnt_next   = '0;
          end else cnt_next = bit_cnt + 6'd1;
          S_CRC: if (bit_cnt == 6'd14) begin
            if (crc_field_bad) begin
              err_hit   = 1'b1;
              err_cause = ERR_CRC;
            end else state_next = S_CRC_DEL;
            cnt_next = '0;
          end else cnt_next = bit_cnt + 6'd1;
          S_CRC_DEL: if (!rx) begin
            err_hit   = 1'b1;
            err_cause = ERR_FORM;
          end else state_next = S_ACK;
          S_ACK: state_next = S_ACK_DEL;
          S_ACK_DEL: if (!rx) begin
            err_hit   = 1'b1;
            err_cause = ERR_FORM;
          end else begin
            state_next = S_EOF;
            cnt_next   = '0;
          end
          // The seventh EOF bit may be dominant without error.
          S_EOF: if (bit_cnt == 6'd6) begin
            frame_done = 1'b1;
            state_next = S_INTERM;
            cnt_next   = '0;
          end else if (!rx) begin
            err_hit   = 1'b1;
            err_cause = ERR_FORM;
          end else cnt_next = bit_cnt + 6'd1;
          S_INTERM: if (!rx) cnt_next = '0;
          else if (bit_cnt == 6'd2) begin
            state_next = S_IDLE;
            cnt_next   = '0;
          end else cnt_next = bit_cnt + 6'd1;
          S_WAIT_IDLE: if (!rx) cnt_next = '0;
          else if (bit_cnt == 6'd10) begin
            state_next = S_IDLE;
            cnt_next   = '0;
          end else cnt_next = bit_cnt + 6'd1;
          default: begin
            state_next = S_IDLE;
            cnt_next   = '0;
          end
        endcase
      end
      if (err_hit) begin
        state_next = S_WAIT_IDLE;
        cnt_next   = '0;
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      id_sr     <= '0;
      rtr_sr    <= 1'b0;
      dlc_sr    <= '0;
      data_sr   <= '0;
      data_last <= '0;
    end else if (bit_ok) begin
      case (state)
        S_IDLE: if (state_next == S_ID) data_sr <= '0;
        S_ID:   id_sr <= {id_sr[9:0], rx};
        S_RTR:  rtr_sr <= rx;
        S_DLC: begin
          dlc_sr <= dlc_full;
          if (bit_cnt == 6'd3) data_last <= data_last_nx;
        end
        // Byte n arrives first, MSB first, and lands at [8n+7:8n].
        S_DATA: data_sr[{bit_cnt[5:3], ~bit_cnt[2:0]}] <= rx;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      frame_valid_r <= 1'b0;
      error_r       <= 1'b0;
      error_code_r  <= '0;
      id_r          <= '0;
      rtr_r         <= 1'b0;
      dlc_r         <= '0;
      data_r        <= '0;
    end else begin
      frame_valid_r <= frame_done;
      error_r       <= err_hit;
      if (err_hit) error_code_r <= err_cause;
      if (frame_done) begin
        id_r   <= id_sr;
        rtr_r  <= rtr_sr;
        dlc_r  <= dlc_sr;
        data_r <= data_sr;
      end
    end
  end

  always_comb begin
    bus.o_Frame_Valid = frame_valid_r;
    bus.o_Error       = error_r;
    bus.o_Error_Code  = error_code_r;
    bus.o_Id          = id_r;
    bus.o_Rtr         = rtr_r;
    bus.o_Dlc         = dlc_r;
    bus.o_Data        = data_r;
    bus.o_Busy        = (state != S_IDLE);
  end

endmodule
